// File: rtl/irq_collect_if.sv
// ============================================================================
// Module   : irq_collect_if
// Purpose  : Register access bus between the PS register shim and irq_collect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_collect_if;
    logic        wren_i;
    logic        rden_i;
    logic [1:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (
        output wren_i,
        output rden_i,
        output addr_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  wren_i,
        input  rden_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o
    );
endinterface

`default_nettype wire

// File: rtl/irq_collect.sv
// ============================================================================
// Module   : irq_collect
// Purpose  : Latches PL interrupt sources as pending, masks them, and drives a
//            stretched irq line to the GIC. Optional macro IRQ_COLLECT_CNT_EN
//            adds a rising-edge counter on register 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_collect #(
    parameter int NSRC   = 4,
    parameter int MIN_HI = 4,
    parameter int MIN_LO = 2
) (
    input  wire logic            clk100,
    input  wire logic            rst_n,
    input  wire logic [NSRC-1:0] src_i,
    output logic      [NSRC-1:0] src_clr_o,
    output logic                 irq_o,
    irq_collect_if.slave         bus
);

    localparam int TMAX = (MIN_HI > MIN_LO) ? MIN_HI : MIN_LO;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] c_HI_LOAD = TW'(MIN_HI - 1);
    localparam logic [TW-1:0] c_LO_LOAD = TW'(MIN_LO - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ASSERT = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;
    localparam logic [1:0] c_GAP    = 2'd3;

    logic [NSRC-1:0] src_q, pend_q, pend_d, en_q, en_d, mode_q, mode_d, clr_q;
    logic [NSRC-1:0] w_set, w_w1c;
    logic [1:0]      state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            irq_q, irq_d;
    logic [31:0]     rdata_q, rdata_d, w_rd_val;
    logic            w_req, w_wr_status, w_wr_enable, w_wr_mode;
    logic            w_unused_wdata;

    assign w_wr_status    = bus.wren_i && (bus.addr_i == 2'd0);
    assign w_wr_enable    = bus.wren_i && (bus.addr_i == 2'd1);
    assign w_wr_mode      = bus.wren_i && (bus.addr_i == 2'd2);
    assign w_unused_wdata = ^bus.wdata_i;

    always_comb begin
        w_set  = (mode_q & src_i & ~src_q) | (~mode_q & src_i);
        w_w1c  = w_wr_status ? bus.wdata_i[NSRC-1:0] : '0;
        // Set is ORed in after the clear so a simultaneous event is never lost
        pend_d = (pend_q & ~w_w1c) | w_set;
        en_d   = w_wr_enable ? bus.wdata_i[NSRC-1:0] : en_q;
        mode_d = w_wr_mode   ? bus.wdata_i[NSRC-1:0] : mode_q;
        w_req  = |(pend_q & en_q);
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            c_IDLE: begin
                if (w_req) begin
                    state_d = c_ASSERT;
                    tmr_d   = c_HI_LOAD;
                end
            end
            c_ASSERT: begin
                if (tmr_q == '0) begin
                    if (w_req) begin
                        state_d = c_HOLD;
                    end else begin
                        state_d = c_GAP;
                        tmr_d   = c_LO_LOAD;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            c_HOLD: begin
                if (!w_req) begin
                    state_d = c_GAP;
                    tmr_d   = c_LO_LOAD;
                end
            end
            c_GAP: begin
                if (tmr_q == '0) begin
                    if (w_req) begin
                        state_d = c_ASSERT;
                        tmr_d   = c_HI_LOAD;
                    end else begin
                        state_d = c_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
        irq_d = (state_d == c_ASSERT) || (state_d == c_HOLD);
    end

`ifdef IRQ_COLLECT_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        w_wr_count;

    assign w_wr_count = bus.wren_i && (bus.addr_i == 2'd3);

    always_comb begin
        cnt_d = cnt_q;
        if (w_wr_count) begin
            cnt_d = '0;
        end else if (irq_d && !irq_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        w_rd_val = '0;
        case (bus.addr_i)
            2'd0: w_rd_val[NSRC-1:0] = pend_q;
            2'd1: w_rd_val[NSRC-1:0] = en_q;
            2'd2: w_rd_val[NSRC-1:0] = mode_q;
`ifdef IRQ_COLLECT_CNT_EN
            2'd3: w_rd_val = cnt_q;
`else
            2'd3: w_rd_val = '0;
`endif
            default: w_rd_val = '0;
        endcase
        rdata_d = bus.rden_i ? w_rd_val : rdata_q;
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            clr_q   <= '0;
            state_q <= c_IDLE;
            tmr_q   <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            src_q   <= src_i;
            pend_q  <= pend_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            clr_q   <= w_w1c;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign src_clr_o   = clr_q;
    assign irq_o       = irq_q;
    assign bus.rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_collect.sv
// ============================================================================
// Module   : tb_irq_collect
// Purpose  : Directed bench for irq_collect with a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_collect;
    localparam int NSRC = 4;
`ifdef IRQ_COLLECT_CNT_EN
    localparam logic [31:0] c_CNT_ONE = 32'd1;
`else
    localparam logic [31:0] c_CNT_ONE = 32'd0;
`endif

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
    } rd_t;

    logic            clk100 = 1'b0;
    logic            rst_n  = 1'b0;
    logic [NSRC-1:0] src_i  = '0;
    logic [NSRC-1:0] src_clr_o;
    logic            irq_o;
    logic            rd_v   = 1'b0;
    logic [13:0]     tr;
    rd_t             exp_q[$];
    int              checks   = 0;
    int              failures = 0;

    irq_collect_if bus();

    irq_collect #(.NSRC(NSRC), .MIN_HI(4), .MIN_LO(2)) dut (
        .clk100    (clk100),
        .rst_n     (rst_n),
        .src_i     (src_i),
        .src_clr_o (src_clr_o),
        .irq_o     (irq_o),
        .bus       (bus)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Read data appears the cycle after rden_i; compare against the queued expectation
    always @(posedge clk100) rd_v <= bus.rden_i;

    always @(negedge clk100) begin
        if (rd_v) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", bus.rdata_o, 32'hDEAD_BEEF);
            end else begin
                rd_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd%0d", e.a), bus.rdata_o, e.d);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.wren_i  = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        @(negedge clk100);
        bus.wren_i  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e);
        bus.rden_i = 1'b1;
        bus.addr_i = a;
        exp_q.push_back('{a: a, d: e});
        @(negedge clk100);
        bus.rden_i = 1'b0;
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e);
        bus.rden_i  = 1'b1;
        bus.wren_i  = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        exp_q.push_back('{a: a, d: e});
        @(negedge clk100);
        bus.rden_i  = 1'b0;
        bus.wren_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wren_i  = 1'b0;
        bus.rden_i  = 1'b0;
        bus.addr_i  = 2'd0;
        bus.wdata_i = '0;
        tick(2);
        chk("rst_irq",   {31'd0, irq_o}, 32'd0);
        chk("rst_clr",   {28'd0, src_clr_o}, 32'd0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) rd(2'(i), 32'd0);

        // Edge mode on source 0; read-during-write returns the old value
        wr(2'd2, 32'h1);
        rdwr(2'd1, 32'hFFFF_FFF1, 32'h0);
        rd(2'd1, 32'h1);
        src_i[0] = 1'b1;
        chk("edge_lat0", {31'd0, irq_o}, 32'd0);
        tick(1);
        chk("edge_lat1", {31'd0, irq_o}, 32'd0);
        tick(1);
        chk("edge_lat2", {31'd0, irq_o}, 32'd1);
        tick(3);
        rd(2'd0, 32'h1);
        wr(2'd0, 32'h1);
        chk("edge_clr_on",  {28'd0, src_clr_o}, 32'h1);
        tick(1);
        chk("edge_clr_off", {28'd0, src_clr_o}, 32'h0);
        rd(2'd0, 32'h0);
        tick(2);
        chk("edge_drop", {31'd0, irq_o}, 32'd0);
        src_i[0] = 1'b0;
        tick(6);

        // Level mode on source 1 re-sets after clear while held high
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h2);
        src_i[1] = 1'b1;
        tick(3);
        rd(2'd0, 32'h2);
        wr(2'd0, 32'h2);
        chk("lvl_clr", {28'd0, src_clr_o}, 32'h2);
        rd(2'd0, 32'h2);
        src_i[1] = 1'b0;
        tick(1);
        wr(2'd0, 32'h2);
        rd(2'd0, 32'h0);
        rd(2'd2, 32'h0);
        tick(3);
        chk("lvl_drop", {31'd0, irq_o}, 32'd0);
        tick(4);

        // Masked source stays pending without driving irq until enabled
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h4);
        src_i[2] = 1'b1;
        tick(4);
        chk("mask_off", {31'd0, irq_o}, 32'd0);
        rd(2'd0, 32'h4);
        wr(2'd1, 32'h4);
        chk("en_lat1", {31'd0, irq_o}, 32'd0);
        tick(1);
        chk("en_lat2", {31'd0, irq_o}, 32'd1);
        src_i[2] = 1'b0;
        wr(2'd0, 32'h4);
        tick(8);
        chk("mask_drop", {31'd0, irq_o}, 32'd0);

        // Stretch to MIN_HI, then a new event during the gap after MIN_LO
        wr(2'd1, 32'h8);
        wr(2'd2, 32'h8);
        for (int k = 0; k < 14; k++) begin
            tr[k] = irq_o;
            case (k)
                0: src_i[3] = 1'b1;
                1: begin
                    src_i[3]    = 1'b0;
                    bus.wren_i  = 1'b1;
                    bus.addr_i  = 2'd0;
                    bus.wdata_i = 32'h8;
                end
                2: bus.wren_i = 1'b0;
                6: src_i[3] = 1'b1;
                7: src_i[3] = 1'b0;
                default: ;
            endcase
            tick(1);
        end
        chk("stretch_gap", {18'd0, tr}, {18'd0, 14'b11111100111100});
        rd(2'd0, 32'h8);
        wr(2'd0, 32'h8);
        tick(8);

        // Set and clear of the same bit in one cycle: set wins
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h1);
        src_i[0]    = 1'b1;
        bus.wren_i  = 1'b1;
        bus.addr_i  = 2'd0;
        bus.wdata_i = 32'h1;
        tick(1);
        bus.wren_i  = 1'b0;
        chk("coll_clr", {28'd0, src_clr_o}, 32'h1);
        rd(2'd0, 32'h1);

        wr(2'd3, 32'h1234_5678);
        rd(2'd3, 32'h0);
        wr(2'd1, 32'h1);
        tick(3);
        chk("cnt_irq", {31'd0, irq_o}, 32'd1);
        rd(2'd3, c_CNT_ONE);
`ifdef IRQ_COLLECT_CNT_EN
        wr(2'd1, 32'h0);
        tick(8);
        force dut.cnt_q = 32'hFFFF_FFFF;
        tick(1);
        release dut.cnt_q;
        wr(2'd1, 32'h1);
        tick(3);
        rd(2'd3, 32'h0);
`endif

        // Asynchronous reset in HOLD
        tick(6);
        chk("pre_rst", {31'd0, irq_o}, 32'd1);
        src_i = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_async_clr", {28'd0, src_clr_o}, 32'd0);
        @(negedge clk100);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) rd(2'(i), 32'd0);

        tick(2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(1);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
